// File: rtl/iir_pkg.sv
// Shared definitions for the IIR filter stages: FSM encoding, clog2 and the
// round-half-up / saturate helpers used by both feed-forward and feedback paths.
package iir_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        RES,
        HOLD
    } fb_state_e;

    // Working width of the round/saturate helpers; every accumulator must fit.
    localparam int RS_WIDTH = 64;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result++;
            v = v >> 1;
        end
        return result;
    endfunction

    function automatic logic signed [RS_WIDTH-1:0] round_shift(
        input logic signed [RS_WIDTH-1:0] acc,
        input int                         frac
    );
        logic signed [RS_WIDTH-1:0] half;
        half = RS_WIDTH'(1) <<< (frac - 1);
        return (acc + half) >>> frac;
    endfunction

    function automatic logic sat_ovf(
        input logic signed [RS_WIDTH-1:0] x,
        input int                         prec
    );
        logic signed [RS_WIDTH-1:0] max_v;
        logic signed [RS_WIDTH-1:0] min_v;
        max_v = (RS_WIDTH'(1) <<< (prec - 1)) - RS_WIDTH'(1);
        min_v = -(RS_WIDTH'(1) <<< (prec - 1));
        return (x > max_v) || (x < min_v);
    endfunction

    function automatic logic signed [RS_WIDTH-1:0] sat_clamp(
        input logic signed [RS_WIDTH-1:0] x,
        input int                         prec
    );
        logic signed [RS_WIDTH-1:0] max_v;
        logic signed [RS_WIDTH-1:0] min_v;
        max_v = (RS_WIDTH'(1) <<< (prec - 1)) - RS_WIDTH'(1);
        min_v = -(RS_WIDTH'(1) <<< (prec - 1));
        if (x > max_v) begin
            return max_v;
        end else if (x < min_v) begin
            return min_v;
        end
        return x;
    endfunction

    function automatic logic signed [RS_WIDTH-1:0] round_sat(
        input logic signed [RS_WIDTH-1:0] acc,
        input int                         frac,
        input int                         prec
    );
        return sat_clamp(round_shift(acc, frac), prec);
    endfunction

endpackage

// File: rtl/iir_round_sat.sv
// Combinational round-half-toward-+inf followed by a clamp to OUT_WIDTH signed,
// with a flag marking when the clamp engaged.
module iir_round_sat
    import iir_pkg::*;
#(
    parameter int IN_WIDTH  = 26,
    parameter int OUT_WIDTH = 16,
    parameter int FRAC      = 6
) (
    input  logic signed [IN_WIDTH-1:0]  din,
    output logic signed [OUT_WIDTH-1:0] dout,
    output logic                        ovf
);

    logic signed [RS_WIDTH-1:0] din_wide;

    assign din_wide = {{(RS_WIDTH - IN_WIDTH){din[IN_WIDTH-1]}}, din};
    assign dout     = OUT_WIDTH'(round_sat(din_wide, FRAC, OUT_WIDTH));
    assign ovf      = sat_ovf(round_shift(din_wide, FRAC), OUT_WIDTH);

endmodule

// File: rtl/iir_fb.sv
// Feedback (denominator) stage of the IIR filter: y[n] = w[n] - sum a[k]*y[n-k],
// evaluated one tap per cycle on a single shared multiply-accumulator.
module iir_fb
    import iir_pkg::*;
#(
    parameter int M           = 2,
    parameter int PRECISION   = 16,
    parameter int COEFF_WIDTH = 8,
    parameter int FRAC        = 6
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clr,
    input  logic signed [PRECISION-1:0]   w,
    input  logic                          w_valid,
    output logic                          w_ready,
    input  logic [COEFF_WIDTH*M-1:0]      packed_a_coeffs,
    output logic signed [PRECISION-1:0]   y,
    output logic                          y_valid,
    input  logic                          y_ready,
    output logic                          busy,
    output logic                          sat
);

    localparam int ACC_WIDTH  = PRECISION + COEFF_WIDTH + clog2(M) + 1;
    localparam int PROD_WIDTH = PRECISION + COEFF_WIDTH;
    localparam int K_WIDTH    = (M > 1) ? clog2(M) : 1;
    localparam logic [K_WIDTH-1:0] K_LAST = K_WIDTH'(M - 1);

    fb_state_e                     state_q;
    fb_state_e                     state_d;
    logic signed [ACC_WIDTH-1:0]   acc;
    logic [K_WIDTH-1:0]            k;
    logic signed [COEFF_WIDTH-1:0] a_in [M];
    logic signed [COEFF_WIDTH-1:0] a_q  [M];
    logic signed [PRECISION-1:0]   yh   [M];
    logic signed [PROD_WIDTH-1:0]  prod;
    logic signed [PRECISION-1:0]   r_sat;
    logic                          r_ovf;

    // Index 0 holds a[1] and y[n-1]; the tap counter runs 0..M-1.
    for (genvar i = 0; i < M; i++) begin : g_unpack
        assign a_in[i] = packed_a_coeffs[COEFF_WIDTH*i +: COEFF_WIDTH];
    end

    assign prod    = a_q[k] * yh[k];
    assign w_ready = (state_q == IDLE);
    assign busy    = (state_q != IDLE);

    iir_round_sat #(
        .IN_WIDTH (ACC_WIDTH),
        .OUT_WIDTH(PRECISION),
        .FRAC     (FRAC)
    ) u_round_sat (
        .din (acc),
        .dout(r_sat),
        .ovf (r_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (w_valid) state_d = MAC;
                MAC:     if (k == K_LAST) state_d = RES;
                RES:     state_d = HOLD;
                HOLD:    if (y_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Clear wipes history and the sticky flag but deliberately leaves y alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            k       <= '0;
            y       <= '0;
            y_valid <= 1'b0;
            sat     <= 1'b0;
            for (int i = 0; i < M; i++) begin
                a_q[i] <= '0;
                yh[i]  <= '0;
            end
        end else if (clr) begin
            y_valid <= 1'b0;
            sat     <= 1'b0;
            for (int i = 0; i < M; i++) begin
                yh[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (w_valid) begin
                        acc <= {{(ACC_WIDTH - PRECISION - FRAC){w[PRECISION-1]}}, w, {FRAC{1'b0}}};
                        k   <= '0;
                        for (int i = 0; i < M; i++) begin
                            a_q[i] <= a_in[i];
                        end
                    end
                end
                MAC: begin
                    acc <= acc - {{(ACC_WIDTH - PROD_WIDTH){prod[PROD_WIDTH-1]}}, prod};
                    k   <= k + 1'b1;
                end
                RES: begin
                    y       <= r_sat;
                    y_valid <= 1'b1;
                    yh[0]   <= r_sat;
                    for (int i = 1; i < M; i++) begin
                        yh[i] <= yh[i-1];
                    end
                    if (r_ovf) begin
                        sat <= 1'b1;
                    end
                end
                HOLD: begin
                    if (y_ready) begin
                        y_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/iir_fb.md
# iir_fb

Feedback (recursive, denominator) stage of the configurable IIR filter. It takes the feed-forward partial result `w[n]` and produces `y[n] = w[n] - sum_{k=1..M} a[k]*y[n-k]`. A single time-multiplexed multiply-accumulator evaluates the sum, one tap per cycle. The block sits directly downstream of the feed-forward stage, with valid/ready handshakes on both sides.

## Interface
- `M`, 2: feedback order (number of `a` taps, `a[1]..a[M]`), 1..16.
- `PRECISION`, 16: sample width, signed two's complement.
- `COEFF_WIDTH`, 8: coefficient width, signed.
- `FRAC`, 6: coefficient fractional bits, 1..COEFF_WIDTH-1.
- `ACC_WIDTH` (localparam): PRECISION+COEFF_WIDTH+clog2(M)+1.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `clr`  in  1  synchronous clear: history, sticky flag, and FSM return to idle.
- `w`  in  PRECISION  signed input sample.
- `w_valid`  in  1  input valid.
- `w_ready`  out  1  input ready.
- `packed_a_coeffs`  in  COEFF_WIDTH*M  `a[k]` occupies bits `[COEFF_WIDTH*k-1 : COEFF_WIDTH*(k-1)]`.
- `y`  out  PRECISION  signed output sample.
- `y_valid`  out  1  output valid.
- `y_ready`  in  1  output ready.
- `busy`  out  1  high in any state other than IDLE.
- `sat`  out  1  sticky saturation flag.

## Operation
- FSM states: IDLE, MAC, RES, HOLD.
- **IDLE**
  - `w_ready=1`.
  - On `w_valid&w_ready`:
    - `acc <= sext(w) <<< FRAC`.
    - All `a[k]` are latched into a coefficient register.
    - `k <= 1`.
    - Next state MAC.
- **MAC**
  - Each cycle: `acc <= acc - a[k]*yh[k]`, `k <= k+1`.
  - After the M-th tap, next state RES.
  - `yh[k]` holds `y[n-k]`.
- **RES**
  - `r = (acc + 2^(FRAC-1)) >>> FRAC`, i.e. round half toward +inf.
  - `r` is clamped to [-2^(PRECISION-1), 2^(PRECISION-1)-1].
  - Register updates: `y <= clamp(r)`, history shift `yh[k] <= yh[k-1]`, `yh[1] <= clamp(r)`, `y_valid <= 1`.
  - If clamping occurred, `sat <= 1`.
  - Next state HOLD.
- **HOLD**
  - `y` and `y_valid` are stable until `y_valid&y_ready`.
  - At that edge: `y_valid <= 0`, next state IDLE.
- `w_ready` is 0 in every state except IDLE.
- Coefficient changes after acceptance do not affect the sample in flight.
- The accumulator never wraps: ACC_WIDTH covers the worst case.
- `clr`:
  - Takes priority in any state.
  - `yh[*] <= 0`, `sat <= 0`, `y_valid <= 0`, next state IDLE.
  - A sample in flight is discarded, and `y` keeps its old value.
  - `clr` together with `w_valid` in IDLE: the sample is not accepted.
- Only `clr` and reset clear `sat`.
- Small rounding limit cycles (e.g. a persistent ±1) are permitted behaviour.

## Timing
- Reset values: `y=0`, `y_valid=0`, `w_ready=1`, `busy=0`, `sat=0`, history 0, state IDLE.
- Reset mid-MAC aborts immediately; no output is produced.
- Cycle timing, with acceptance edge E0:
  - MAC taps occur at E1..EM.
  - RES is evaluated at E(M+1).
  - `y_valid` is high from just after E(M+1).
  - Latency is M+1 cycles from acceptance to `y_valid`.
- Maximum throughput is one sample per M+3 cycles: accept, M taps, RES, one HOLD cycle with `y_ready=1`.
- Backpressure on `y_ready` stalls HOLD indefinitely. `w_ready` stays low for the whole stall.

## Structure
- Shared package `iir_pkg` holds:
  - `clog2` function.
  - Round/saturate function shared with the feed-forward stage.
  - FSM state encoding constants.
- One natural sub-module: `iir_round_sat` (combinational round plus clamp, with an overflow output). It is reused when the feed-forward stage output is hardened.
- MAC, history, and FSM stay inline in `iir_fb`.

## Test plan
All scenarios use M=2, PRECISION=16, COEFF_WIDTH=8, FRAC=6, `y_ready=1` unless noted.
- **Passthrough:** `a=0`; input 1000, -5, 32767 → `y` = 1000, -5, 32767. `y_valid` rises 3 cycles after each accept; `sat=0`.
- **First-order decay:** `a[1]=-32` (-0.5), `a[2]=0`; input 1000 then zeros → `y` = 1000, 500, 250, 125, 63, 32, 16, 8, 4, 2, 1, 1.
- **Saturation:** `a[1]=-64` (-1.0); input 20000 twice → `y` = 20000, 32767; `sat` goes to 1 and stays 1 until `clr`.
- **Backpressure:** `y_ready` low for 5 cycles after `y_valid` → `y` stable and `w_ready=0` throughout. The sample is released on the edge where `y_ready` returns high; `w_ready=1` the following cycle.
- **Mid-flight coefficient change / `clr`:** change `a[1]` during MAC → result uses the latched value. Assert `clr` during MAC → no `y_valid`, history zero, next input 7 yields `y=7`.
- **Async reset** asserted during HOLD → `y=0`, `y_valid=0`, `w_ready=1` immediately, with no clock edge required.
